seg_display_mux: RTL
====================

# seg_display_mux

Parametrised multiplexed seven-segment display driver. It accepts a binary value on a load strobe and converts it to BCD with a sequential shift-add-3 converter. It then scans the digits at a prescaled refresh rate with leading-zero blanking, per-digit decimal points and overflow indication. It replaces the fixed 4-digit, free-running divide/modulo display driver and sits between the calculator datapath and the board's anode/cathode pins.

## Interface
- DIGITS, 4: number of display digits, 1..8
- WIDTH, 13: binary input width, 1..27
- REFRESH_DIV, 100000: Clk cycles per digit; must be at least 1
- Clk  input  1  system clock, rising edge
- Rst_n  input  1  asynchronous, active-low reset; one clock, reset fixed as such
- number  input  WIDTH  unsigned value to display, sampled on load
- load  input  1  single-cycle strobe requesting conversion of number
- blank_lz  input  1  1 = blank leading zeros
- dp  input  DIGITS  decimal point enables, bit DIGITS-1 = leftmost digit; sampled live
- busy  output  1  conversion in progress; load ignored while high
- overflow  output  1  committed value ≥ 10^DIGITS
- Anode  output  DIGITS  active-low digit select, bit DIGITS-1 = leftmost
- LED_o  output  7  active-low segments a..g, MSB = a
- DP_o  output  1  active-low decimal point

## Operation
- Converter FSM:
  - IDLE: load=1 → capture number into the shift register, clear the BCD accumulator, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift left one bit. After exactly WIDTH shifts, go to COMMIT.
  - COMMIT: copy the accumulator to the display digit register, set overflow = (captured value ≥ 10^DIGITS), return to IDLE.
- The display digit register changes only in COMMIT, so the old value is shown until the new one is complete. There is no tearing.
- 10^DIGITS is computed as a 32-bit localparam constant. The comparison is done in 32 bits.
- Scan: a prescaler counts 0..REFRESH_DIV-1. On terminal count, the scan index advances DIGITS-1 → 0, wrapping to DIGITS-1. Leftmost is first.
- Per scanned digit, in priority order:
  - overflow=1 → dash (1111110).
  - blank_lz=1, the digit is not the rightmost, and all digits to its left including itself are zero → blank (1111111).
  - Otherwise the decimal pattern 0–9. Nibble values above 9 map to blank.
- DP_o = ~dp[index], independent of blanking and overflow.
- Exactly one Anode bit is low at any time after the first post-reset cycle.

## Timing
- Reset values:
  - busy=0, overflow=0, digit register=0.
  - Anode=all ones, LED_o=1111111, DP_o=1.
  - Prescaler=0, scan index=DIGITS-1, FSM=IDLE.
- Load accepted at edge E0: busy=1 after E0. Shifts occur at E1..E_WIDTH. COMMIT occurs at E_WIDTH+1, after which busy=0 and overflow is updated.
- Total latency from load to committed value: WIDTH+1 cycles. load is accepted again on the cycle busy is low.
- Anode, LED_o and DP_o are registered every cycle from the scan index and digit register. They have 1-cycle latency, so a commit is visible on the pins one cycle later for the currently scanned digit.
- load while busy: ignored, with no queueing. load in the same cycle as COMMIT: ignored.
- Rst_n asserted mid-conversion: all state returns to reset values immediately, and the partial result is discarded.
- REFRESH_DIV=1: the digit advances every cycle.

## Structure
- Package seg_display_pkg holds:
  - The segment pattern constants SEG_0..SEG_9, SEG_BLANK and SEG_DASH.
  - The FSM state encoding (IDLE, SHIFT, COMMIT).
  - A function pow10(n) returning 32 bits.
- Sub-module bin2bcd_seq (parameters WIDTH, DIGITS): contains the FSM, shift/add-3 datapath, busy flag and COMMIT output bus.
- The top level holds the prescaler, scan index, blanking logic and output registers.

## Test plan
- Bench parameters are REFRESH_DIV=4, DIGITS=4 and WIDTH=13 unless stated otherwise.
- Reset, then 20 cycles → Anode cycles 0111, 1011, 1101, 1110 every 4 cycles. All digits show SEG_0 (0000001) with blank_lz=0.
- load number=1234 → busy high for exactly 14 cycles. The scanned digits then show 1, 2, 3, 4 (1001111, 0010010, 0000110, 1001100).
- number=7, blank_lz=1, dp=0010 → the three left digits show 1111111, the rightmost shows 0001111, and DP_o=0 only on the third digit.
- number=8191 with DIGITS=4 → no overflow, digits 8, 1, 9, 1. Then with DIGITS=3 → overflow=1 and all digits show 1111110.
- Second load 5 cycles into a conversion of 42 → ignored, and 42 is displayed. Then number=0 with blank_lz=1 → only the rightmost digit shows 0000001.
- Rst_n low at cycle 6 of a conversion → busy=0, the display shows 0 and no commit occurs. A new load afterwards converts correctly.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment patterns,
// converter state encoding and small constant helpers.
package seg_display_pkg;

    // Active-low segments, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) p = p * 32'd10;
        return p;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter. One bit per cycle; result and
// overflow flag are presented on o_bcd/o_ovf while o_commit is high.
module bin2bcd_seq
    import seg_display_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load,
    input  logic [WIDTH-1:0]        i_number,
    output logic                    o_busy,
    output logic                    o_commit,
    output logic [DIGITS-1:0][3:0]  o_bcd,
    output logic                    o_ovf
);

    localparam int               CW    = $clog2(WIDTH + 1);
    localparam logic [31:0]      LIMIT = pow10(DIGITS);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);

    conv_state_t                 r_state, w_next;
    logic [WIDTH-1:0]            r_bin;
    logic [DIGITS-1:0][3:0]      r_bcd, w_adj;
    logic [CW-1:0]               r_cnt;
    logic                        r_ovf;
    logic [4*DIGITS+WIDTH-1:0]   w_cat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_load) w_next = SHIFT;
            SHIFT:   if (r_cnt == LAST) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (r_state != IDLE);
        o_commit = (r_state == COMMIT);
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign w_adj[g] = (r_bcd[g] > 4'd4) ? r_bcd[g] + 4'd3 : r_bcd[g];
    end

    // Carries out of the top nibble are dropped; such values show as overflow anyway
    assign w_cat = {w_adj, r_bin} << 1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && i_load) begin
            r_bin <= i_number;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= ({{(32-WIDTH){1'b0}}, i_number} >= LIMIT);
        end else if (r_state == SHIFT) begin
            {r_bcd, r_bin} <= w_cat;
            r_cnt          <= r_cnt + CW'(1);
        end
    end

    assign o_bcd = r_bcd;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver: converts a loaded binary value to BCD and
// scans the digits leftmost-first with blanking, decimal points and overflow dash.
module seg_display_mux
    import seg_display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 13,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [WIDTH-1:0]  number,
    input  logic              load,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp,
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] Anode,
    output logic [6:0]        LED_o,
    output logic              DP_o
);

    localparam int            IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int            PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IW-1:0] IDX_LEFT = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(REFRESH_DIV - 1);

    logic                    w_busy, w_commit, w_ovf;
    logic [DIGITS-1:0][3:0]  w_bcd, r_digits;
    logic                    r_ovf;
    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [DIGITS-1:0]       w_lz;
    logic                    w_zrun;
    logic [6:0]              w_seg;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
        .i_clk    (Clk),
        .i_rst_n  (Rst_n),
        .i_load   (load),
        .i_number (number),
        .o_busy   (w_busy),
        .o_commit (w_commit),
        .o_bcd    (w_bcd),
        .o_ovf    (w_ovf)
    );

    // Display value only moves on commit, so a conversion never tears the display
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_digits <= '0;
            r_ovf    <= 1'b0;
        end else if (w_commit) begin
            r_digits <= w_bcd;
            r_ovf    <= w_ovf;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_presc <= '0;
            r_idx   <= IDX_LEFT;
        end else if (r_presc == PRE_MAX) begin
            r_presc <= '0;
            r_idx   <= (r_idx == '0) ? IDX_LEFT : r_idx - IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // w_lz[i]: digit i and everything left of it are zero
    always_comb begin
        w_lz   = '0;
        w_zrun = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zrun  = w_zrun & (r_digits[i] == 4'd0);
            w_lz[i] = w_zrun;
        end
    end

    always_comb begin
        w_seg = seg_decode(r_digits[r_idx]);
        if (r_ovf)
            w_seg = SEG_DASH;
        else if (blank_lz && r_idx != '0 && w_lz[r_idx])
            w_seg = SEG_BLANK;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Anode <= '1;
            LED_o <= SEG_BLANK;
            DP_o  <= 1'b1;
        end else begin
            Anode <= ~(DIGITS'(1) << r_idx);
            LED_o <= w_seg;
            DP_o  <= ~dp[r_idx];
        end
    end

    assign busy     = w_busy;
    assign overflow = r_ovf;

endmodule
